imem_loader: RTL and testbench

Boot-time writer for the CPU's instruction memory. Accepts a length-prefixed byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, and issues one word write per instruction into the instruction RAM. While loading it holds the CPU core in reset, and releases it once the image is complete and validated.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader bus: start/stream handshake in, instruction-RAM write port and
// boot status out. master = the loader, slave = the host / memory side.
interface imem_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_reset;
    logic        done;
    logic        err;

    modport master (
        input  start, in_valid, in_data,
        output in_ready, we, wa, wd, cpu_reset, done, err
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, we, wa, wd, cpu_reset, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit instruction RAM writes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH_N = 17'(DEPTH);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        accept;
    logic [15:0] hi_len;

    // in_ready is a registered copy of "state accepts bytes", so this is the only transfer qualifier.
    assign accept = bus.in_valid && bus.in_ready;
    assign hi_len = {bus.in_data, len_lo};

    // NOTE: every state and output register here is assigned with <= so all
    // of them update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            len_lo        <= '0;
            len           <= '0;
            word_idx      <= '0;
            byte_cnt      <= '0;
            asm_buf       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
            bus.in_ready  <= 1'b0;
            bus.we        <= 1'b0;
            bus.wa        <= '0;
            bus.wd        <= '0;
            bus.cpu_reset <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= LEN_LO;
                        bus.in_ready <= 1'b1;
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len_lo <= bus.in_data;
                        state  <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        len <= hi_len;
                        if (hi_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state         <= CSUM;
`else
                            state         <= DONE;
                            bus.in_ready  <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
`endif
                        end else if ({1'b0, hi_len} > DEPTH_N) begin
                            state        <= ERR;
                            bus.in_ready <= 1'b0;
                            bus.err      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            bus.wd   <= {bus.in_data, asm_buf};
                            bus.wa   <= {14'd0, word_idx, 2'b00};
                            bus.we   <= 1'b1;
                            word_idx <= word_idx + 16'd1;
                            if (word_idx == len - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state        <= CSUM;
`else
                                // done follows one cycle later, from the DONE state itself
                                state        <= DONE;
                                bus.in_ready <= 1'b0;
`endif
                            end
                        end else begin
                            // bytes enter at the top and shift down: first byte ends in [7:0]
                            asm_buf <= {bus.in_data, asm_buf[23:8]};
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data == csum) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
                        end else begin
                            state   <= ERR;
                            bus.err <= 1'b1;
                        end
                    end
                end
`endif

                DONE, ERR: begin
                    if (bus.start) begin
                        state         <= LEN_LO;
                        bus.in_ready  <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.err       <= 1'b0;
                        bus.cpu_reset <= 1'b1;
                        word_idx      <= '0;
                        byte_cnt      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum          <= '0;
`endif
                    end else if (state == DONE) begin
                        bus.done      <= 1'b1;
                        bus.cpu_reset <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven,
// popped and compared whenever the DUT pulses we. Honors IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [31:0] words[$];

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every we pulse must match the oldest pending write.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_we", 64'(bus.we), 64'd0);
            else check("write", {bus.wa, bus.wd}, exp_q.pop_front());
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ready_after_start", 64'(bus.in_ready), 64'd1);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int n = 0;
        if (gappy) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
        else @(negedge clk);
    endtask

    task automatic run_load(input int n, input bit gappy, input bit bad_csum);
        logic [15:0] len;
        logic [7:0]  x;
        logic [31:0] w;
        bit          ok;
        bit          late;
        len = 16'(n);
        x   = 8'd0;
        ok  = (n <= DEPTH);
        pulse_start();
        send_byte(len[7:0], gappy);
        send_byte(len[15:8], gappy);
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                w = words[k];
                exp_q.push_back({32'(4 * k), w});
                for (int b = 0; b < 4; b++) begin
                    x = x ^ w[8*b +: 8];
                    send_byte(w[8*b +: 8], gappy);
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (ok) send_byte(bad_csum ? ~x : x, gappy);
        ok   = ok && !bad_csum;
        late = 1'b0;
`else
        late = ok && (n > 0);
`endif
        bus.in_valid = 1'b0;
        if (late) begin
            check("done_not_yet", 64'(bus.done), 64'd0);
            @(negedge clk);
        end
        check("done", 64'(bus.done), 64'(ok));
        check("err", 64'(bus.err), 64'(!ok));
        check("cpu_reset", 64'(bus.cpu_reset), 64'(!ok));
        check("ready_low", 64'(bus.in_ready), 64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill_fixed();
        words.delete();
        words.push_back(32'h0050_0013);
        words.push_back(32'h0000_02B3);
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_wa", 64'(bus.wa), 64'd0);
        check("rst_wd", 64'(bus.wd), 64'd0);
        check("rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        reset = 1'b0;

        // idle: stray bytes are not consumed and nothing is written
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check("idle_ready", 64'(bus.in_ready), 64'd0);
        check("idle_cpu_reset", 64'(bus.cpu_reset), 64'd1);

        fill_fixed();
        run_load(2, 1'b0, 1'b0);
        check("hold_wa", 64'(bus.wa), 64'h4);
        check("hold_wd", 64'(bus.wd), 64'h0000_02B3);

        fill_fixed();
        run_load(2, 1'b1, 1'b0);

        words.delete();
        run_load(0, 1'b0, 1'b0);

        run_load(DEPTH + 1, 1'b0, 1'b0);
        fill_fixed();
        run_load(2, 1'b0, 1'b0);

        fill_random(DEPTH);
        run_load(DEPTH, 1'b0, 1'b0);

        // reset in the middle of word 1 of an N=3 load
        fill_random(3);
        pulse_start();
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        exp_q.push_back({32'd0, words[0]});
        for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8], 1'b0);
        send_byte(words[1][7:0], 1'b0);
        send_byte(words[1][15:8], 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_pending", 64'(exp_q.size()), 64'd0);
        check("mid_ready", 64'(bus.in_ready), 64'd0);
        check("mid_we", 64'(bus.we), 64'd0);
        check("mid_wa", 64'(bus.wa), 64'd0);
        check("mid_wd", 64'(bus.wd), 64'd0);
        check("mid_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        check("mid_done", 64'(bus.done), 64'd0);
        check("mid_err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        fill_fixed();
        run_load(2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        fill_fixed();
        run_load(2, 1'b0, 1'b1);
        fill_random(5);
        run_load(5, 1'b1, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
